// File: rtl/gate_sweep_checker.sv
// Stimulus/check stage for a 2-input universal gate: sweeps all four input vectors,
// samples the gate after a settle interval and counts truth-table mismatches.
// Optional first-mismatch capture is built when GATE_SWEEP_FIRST_FAIL_EN is defined.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             gate_in1,
  output logic             gate_in2,
  input  logic             gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_obs
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic              mode_q, mode_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              pass_q, pass_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [PC_W-1:0]   pcnt_q, pcnt_d;
  logic              settle_last_s;
  logic              pass_last_s;
  logic              expected_s;
  logic              mismatch_s;

  assign settle_last_s = !(settle_q < SC_W'(SETTLE_CYCLES - 1));
  assign pass_last_s   = !(pcnt_q < PC_W'(PASSES - 1));
  assign expected_s    = mode_q ? ~(vec_q[1] | vec_q[0]) : ~(vec_q[1] & vec_q[0]);
  assign mismatch_s    = (gate_out != expected_s);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE; else state_d = S_IDLE;
      S_DRIVE:  if (settle_last_s) state_d = S_SAMPLE; else state_d = S_DRIVE;
      S_SAMPLE: if ((vec_q != 2'd3) || !pass_last_s) state_d = S_DRIVE; else state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: vector stepping, settle/pass counters, saturating error count
  always_comb begin
    vec_d    = vec_q;
    mode_d   = mode_q;
    err_d    = err_q;
    pass_d   = pass_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          vec_d    = 2'd0;
          err_d    = '0;
          pass_d   = 1'b0;
          settle_d = '0;
          pcnt_d   = '0;
        end else begin
          vec_d = vec_q;
        end
      end
      S_DRIVE: begin
        if (!settle_last_s) settle_d = settle_q + SC_W'(1); else settle_d = settle_q;
      end
      S_SAMPLE: begin
        if (mismatch_s && (err_q != {ERR_W{1'b1}})) err_d = err_q + ERR_W'(1);
        else err_d = err_q;
        if (vec_q != 2'd3) begin
          vec_d    = vec_q + 2'd1;
          settle_d = '0;
        end else if (!pass_last_s) begin
          vec_d    = 2'd0;
          pcnt_d   = pcnt_q + PC_W'(1);
          settle_d = '0;
        end else begin
          pass_d = (err_d == '0);
        end
      end
      S_DONE:  vec_d = vec_q;
      default: vec_d = vec_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q    <= 2'd0;
      mode_q   <= 1'b0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      settle_q <= '0;
      pcnt_q   <= '0;
    end else begin
      vec_q    <= vec_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
    end
  end

`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic [1:0] ffv_q, ffv_d;
  logic       ffo_q, ffo_d;

  // First-mismatch capture: the error count is still zero only before the first miss
  always_comb begin
    ffv_d = ffv_q;
    ffo_d = ffo_q;
    if ((state_q == S_IDLE) && start) begin
      ffv_d = 2'd0;
      ffo_d = 1'b0;
    end else if ((state_q == S_SAMPLE) && mismatch_s && (err_q == '0)) begin
      ffv_d = vec_q;
      ffo_d = gate_out;
    end else begin
      ffv_d = ffv_q;
    end
  end

  // Capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ffv_q <= 2'd0;
      ffo_q <= 1'b0;
    end else begin
      ffv_q <= ffv_d;
      ffo_q <= ffo_d;
    end
  end

  assign first_fail_vec = ffv_q;
  assign first_fail_obs = ffo_q;
`else
  assign first_fail_vec = 2'd0;
  assign first_fail_obs = 1'b0;
`endif

  // Output decode from registered state
  always_comb begin
    busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    err_count = err_q;
    gate_in1  = vec_q[1];
    gate_in2  = vec_q[0];
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Sequential stimulus and check stage that wraps a 2-input universal gate (NAND or NOR).
- Drives the gate inputs through all four input vectors, waits a settle interval, samples the gate output and compares it with the expected truth-table value.
- Counts mismatches and reports pass/fail through a start/done handshake.
- Sits directly upstream (feeds in1/in2) and downstream (consumes out) of the gate under check.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range >= 1.
- PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1.
- ERR_W, 8, width of the mismatch counter; counter saturates.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- mode  input  1  0 = expect NAND, 1 = expect NOR; latched when start is accepted.
- gate_in1  output  1  drives gate input in1; equals vec[1].
- gate_in2  output  1  drives gate input in2; equals vec[0].
- gate_out  input  1  gate output under check.
- busy  output  1  high from the cycle after start is accepted until the final SAMPLE cycle, inclusive.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when the last completed run had zero mismatches; held until the next accepted start.
- err_count  output  ERR_W  mismatch count for the current or last run.
- first_fail_vec  output  2  first mismatching vector (see Optional Feature).
- first_fail_obs  output  1  gate_out value observed at the first mismatch (see Optional Feature).

Behaviour:
- Reset values: state = IDLE; vec = 0; gate_in1 = 0; gate_in2 = 0; busy = 0; done = 0; pass = 0; err_count = 0; first_fail_vec = 0; first_fail_obs = 0; settle counter = 0; pass counter = 0.
- Reset asserted mid-run aborts immediately. The next cycle is IDLE with reset values and no done pulse.

State machine: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start = 1:
  - latch mode; vec <= 0; err_count <= 0; pass <= 0; clear first-fail capture; pass counter <= 0; settle counter <= 0.
  - go to DRIVE.
- IDLE, start = 0: hold. gate_in1/gate_in2 keep their last values.
- DRIVE:
  - gate_in1/gate_in2 reflect vec.
  - Stay while settle counter < SETTLE_CYCLES-1, incrementing it.
  - Otherwise go to SAMPLE.
- SAMPLE (one cycle):
  - expected = ~(in1 & in2) for mode 0; ~(in1 | in2) for mode 1.
  - If gate_out != expected, err_count increments, saturating at 2^ERR_W-1 with no wrap.
  - If vec != 3: vec <= vec+1; settle counter <= 0; go to DRIVE.
  - If vec == 3 and pass counter < PASSES-1: vec <= 0 (wrap); pass counter increments; go to DRIVE.
  - Otherwise go to DONE.
- DONE (one cycle):
  - done = 1; pass = (err_count == 0); busy = 0.
  - Go to IDLE.

Timing and conflict rules:
- Run latency: busy is high for exactly PASSES*4*(SETTLE_CYCLES+1) cycles. done is asserted the cycle after the last SAMPLE.
- start while busy or in DONE is ignored. It is neither queued nor able to restart a run.
- start asserted in the same cycle as rst: rst wins.
- mode changes while busy have no effect on the run.
- gate_out is sampled only in SAMPLE. Glitches during DRIVE are ignored.

Optional Feature:
- Macro: GATE_SWEEP_FIRST_FAIL_EN.
- Defined:
  - On the first mismatch of a run, first_fail_vec <= vec and first_fail_obs <= gate_out.
  - Later mismatches do not overwrite these values.
  - Both are cleared on accepted start and on reset.
- Undefined:
  - No capture registers are built.
  - first_fail_vec and first_fail_obs are tied to 0.
  - All other behaviour is identical.

Test Plan:
1. SETTLE_CYCLES=2, PASSES=1, correct NAND model, mode=0, pulse start -> busy for 12 cycles; vectors 00,01,10,11 each held 3 cycles; done pulse; pass=1; err_count=0.
2. NAND model connected, mode=1 (expect NOR) -> err_count=2 (vectors 01 and 10); pass=0; with GATE_SWEEP_FIRST_FAIL_EN: first_fail_vec=2'b01, first_fail_obs=1.
3. gate_out stuck at 0, mode=0, ERR_W=2, PASSES=2 -> 6 mismatches; err_count saturates at 3; busy for 24 cycles; pass=0.
4. Correct NOR model, mode=1; assert rst in the 5th busy cycle -> next cycle IDLE, busy=0, err_count=0, no done pulse. Then start a new run -> pass=1 after 12 busy cycles.
5. Pulse start again at busy cycle 3, and toggle mode mid-run -> no restart; run completes in 12 busy cycles with the originally latched mode; a single done pulse.
6. Build without GATE_SWEEP_FIRST_FAIL_EN and repeat scenario 2 -> err_count=2; first_fail_vec=0; first_fail_obs=0.
